exception_sequencer: RTL and testbench

Multicycle exception-entry sequencer for the CPU datapath. Samples the invalid-opcode, overflow and divide-by-zero flags, latches one prioritised cause, and drives the exception-vector select that picks handler byte 253/254/255. It also sequences the EPC save, the vector memory read, and the PC load. It sits beside the main control unit, which hands it the bus while `busy` is high.

---
 rtl/except_pkg.sv | 46 ++++
 rtl/except_prio_enc.sv | 32 +++
 rtl/exception_sequencer.sv | 149 ++++++++++++++
 tb/tb_exception_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/except_pkg.sv
// ---------------------------------------------------------------------------
// except_pkg
// Shared definitions for the exception-entry sequencer and the control unit:
//   - sequencer state codes (IDLE, SAVE, READ, WAIT, JUMP)
//   - cause codes reported on the 2-bit cause bus
//   - handler vector byte addresses (253/254/255)
//   - excpt_ctrl encodings that select those vectors
//   - cause_to_ctrl(): the vector-select mux from a cause code
// ---------------------------------------------------------------------------
package except_pkg;

    // Sequencer states.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SAVE = 3'd1;
    localparam logic [2:0] ST_READ = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_JUMP = 3'd4;

    // Cause codes, ordered so that a larger code means a higher priority.
    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OPC  = 2'd1;
    localparam logic [1:0] CAUSE_OVF  = 2'd2;
    localparam logic [1:0] CAUSE_DIV0 = 2'd3;

    // Handler vector byte addresses in memory.
    localparam logic [7:0] VEC_OPC  = 8'd253;
    localparam logic [7:0] VEC_OVF  = 8'd254;
    localparam logic [7:0] VEC_DIV0 = 8'd255;

    // Vector-select encodings; bit 2 is reserved and always zero.
    localparam logic [2:0] EXC_CTRL_OPC  = 3'b000;
    localparam logic [2:0] EXC_CTRL_OVF  = 3'b001;
    localparam logic [2:0] EXC_CTRL_DIV0 = 3'b010;

    // Vector-select mux: maps a latched cause to the excpt_ctrl code.
    function automatic logic [2:0] cause_to_ctrl(input logic [1:0] cause);
        logic [2:0] ctrl;
        case (cause)
            CAUSE_OVF:  ctrl = EXC_CTRL_OVF;
            CAUSE_DIV0: ctrl = EXC_CTRL_DIV0;
            default:    ctrl = EXC_CTRL_OPC;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/except_prio_enc.sv
// ---------------------------------------------------------------------------
// except_prio_enc
// Combinational priority encoder from the three exception flags to a 2-bit
// cause code. Divide-by-zero wins over overflow, which wins over invalid
// opcode. Also usable by the control unit for status reporting.
// Ports:
//   op_invalid_i  in  1  undefined opcode flag
//   overflow_i    in  1  ALU signed overflow flag
//   div_zero_i    in  1  divide-by-zero flag
//   cause_o       out 2  prioritised cause (CAUSE_NONE when no flag set)
// ---------------------------------------------------------------------------
module except_prio_enc
    import except_pkg::*;
(
    input  logic       op_invalid_i,
    input  logic       overflow_i,
    input  logic       div_zero_i,
    output logic [1:0] cause_o
);

    always_comb begin
        cause_o = CAUSE_NONE;
        if (div_zero_i) begin
            cause_o = CAUSE_DIV0;
        end else if (overflow_i) begin
            cause_o = CAUSE_OVF;
        end else if (op_invalid_i) begin
            cause_o = CAUSE_OPC;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// ---------------------------------------------------------------------------
// exception_sequencer
// Multicycle exception-entry sequencer. On a flag in IDLE it latches the
// prioritised cause, saves EPC (pc_in - 4), reads the handler byte from the
// vector table, waits MEM_LATENCY cycles for the data, then loads the PC.
// Parameters:
//   MEM_LATENCY   cycles from mem_rd to valid mem_data_in (1..7)
// Ports:
//   clk           in  1   clock, rising edge
//   reset         in  1   asynchronous reset, active low
//   op_invalid    in  1   undefined opcode flag
//   overflow      in  1   ALU signed overflow flag
//   div_zero      in  1   divide-by-zero flag
//   pc_in         in  32  current PC (faulting address + 4)
//   mem_data_in   in  32  memory read data, [7:0] = handler address
//   excpt_ctrl    out 3   vector select (000/001/010 -> 253/254/255)
//   mem_addr_sel  out 1   steer memory address mux to vector select
//   mem_rd        out 1   memory read strobe
//   epc_write     out 1   EPC load enable
//   epc_data      out 32  pc_in - 4
//   pc_write      out 1   PC load enable
//   pc_data       out 32  zero-extended handler byte
//   busy          out 1   sequencer owns the datapath
//   cause         out 2   latched cause (0 none, 1 opc, 2 ovf, 3 div0)
//   done          out 1   pulse on the final (JUMP) cycle
// ---------------------------------------------------------------------------
module exception_sequencer
    import except_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_invalid,
    input  logic        overflow,
    input  logic        div_zero,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  excpt_ctrl,
    output logic        mem_addr_sel,
    output logic        mem_rd,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_data,
    output logic        busy,
    output logic [1:0]  cause,
    output logic        done
);

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY);

    logic [2:0]  state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [31:0] epc_q,   epc_d;
    logic [7:0]  byte_q,  byte_d;
    logic [1:0]  enc_cause;

    // Only the handler byte of the memory word is meaningful here.
    logic unused_mem_bits;
    assign unused_mem_bits = ^mem_data_in[31:8];

    except_prio_enc u_prio (
        .op_invalid_i (op_invalid),
        .overflow_i   (overflow),
        .div_zero_i   (div_zero),
        .cause_o      (enc_cause)
    );

    // Next-state logic. Flags are looked at only in IDLE, so anything that
    // arrives while busy (including the JUMP cycle) is dropped.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_cause != CAUSE_NONE) begin
                    cause_d = enc_cause;
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                epc_d   = pc_in - 32'd4;
                state_d = ST_READ;
            end
            ST_READ: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Capture on the edge where the counter reaches zero; earlier
                // data on the bus is never sampled.
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    byte_d  = mem_data_in[7:0];
                    state_d = ST_JUMP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_JUMP: begin
                cause_d = CAUSE_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                cause_d = CAUSE_NONE;
                cnt_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            cnt_q   <= 3'd0;
            epc_q   <= 32'd0;
            byte_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            byte_q  <= byte_d;
        end
    end

    // Outputs decode the registered state only, so reset clears them at once
    // and a flag can never reach an output in the same cycle.
    assign busy         = (state_q != ST_IDLE);
    assign epc_write    = (state_q == ST_SAVE);
    assign mem_rd       = (state_q == ST_READ);
    assign mem_addr_sel = (state_q == ST_READ) || (state_q == ST_WAIT);
    assign pc_write     = (state_q == ST_JUMP);
    assign done         = (state_q == ST_JUMP);
    assign cause        = cause_q;
    assign excpt_ctrl   = busy ? cause_to_ctrl(cause_q) : EXC_CTRL_OPC;

    // During SAVE the EPC value is presented alongside epc_write; afterwards
    // the captured copy is held.
    assign epc_data     = epc_write ? (pc_in - 32'd4) : epc_q;
    assign pc_data      = pc_write ? {24'd0, byte_q} : 32'd0;

endmodule

// File: tb/tb_exception_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exception_sequencer
// Drives two sequencers (MEM_LATENCY 1 and 3) from shared inputs and checks
// every cycle against a phase-count reference model: after a flag is taken,
// phase 1 saves EPC, phase 2 reads, phases 3..2+L wait, phase 3+L jumps.
// ---------------------------------------------------------------------------
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_invalid, overflow, div_zero;
    logic [31:0] pc_in, mem_data_in;

    logic [2:0]  excpt_ctrl1, excpt_ctrl3;
    logic        mem_addr_sel1, mem_addr_sel3, mem_rd1, mem_rd3;
    logic        epc_write1, epc_write3, pc_write1, pc_write3;
    logic [31:0] epc_data1, epc_data3, pc_data1, pc_data3;
    logic        busy1, busy3, done1, done3;
    logic [1:0]  cause1, cause3;

    int          checks = 0;
    int          failures = 0;

    // Reference model state, one slot per DUT.
    int          phase [2];
    logic [1:0]  mCause [2];
    logic [7:0]  mByte [2];
    int          lat [2];
    int          doneCount [2];
    bit          randMem;

    always #5 clk = ~clk;

    exception_sequencer #(.MEM_LATENCY(1)) dut1 (
        .clk (clk), .reset (reset),
        .op_invalid (op_invalid), .overflow (overflow), .div_zero (div_zero),
        .pc_in (pc_in), .mem_data_in (mem_data_in),
        .excpt_ctrl (excpt_ctrl1), .mem_addr_sel (mem_addr_sel1), .mem_rd (mem_rd1),
        .epc_write (epc_write1), .epc_data (epc_data1),
        .pc_write (pc_write1), .pc_data (pc_data1),
        .busy (busy1), .cause (cause1), .done (done1)
    );

    exception_sequencer #(.MEM_LATENCY(3)) dut3 (
        .clk (clk), .reset (reset),
        .op_invalid (op_invalid), .overflow (overflow), .div_zero (div_zero),
        .pc_in (pc_in), .mem_data_in (mem_data_in),
        .excpt_ctrl (excpt_ctrl3), .mem_addr_sel (mem_addr_sel3), .mem_rd (mem_rd3),
        .epc_write (epc_write3), .epc_data (epc_data3),
        .pc_write (pc_write3), .pc_data (pc_data3),
        .busy (busy3), .cause (cause3), .done (done3)
    );

    // Highest-numbered pending cause wins.
    function automatic logic [1:0] refCause(input logic oi, input logic ov, input logic dz);
        if (dz) return 2'd3;
        if (ov) return 2'd2;
        if (oi) return 2'd1;
        return 2'd0;
    endfunction

    // Vector select is (handler vector - 253): causes 1/2/3 -> 253/254/255.
    function automatic logic [2:0] refCtrl(input logic [1:0] c);
        if (c == 2'd0) return 3'd0;
        return 3'(int'(c) - 1);
    endfunction

    // Expected {excpt_ctrl, mem_addr_sel, mem_rd, epc_write, pc_write, busy, cause, done}.
    function automatic logic [10:0] expBundle(input int i);
        int  kk;
        int  l;
        bit  act;
        kk  = phase[i];
        l   = lat[i];
        act = (kk != 0);
        return {act ? refCtrl(mCause[i]) : 3'd0,
                (kk >= 2 && kk <= 2 + l), (kk == 2), (kk == 1), (kk == 3 + l),
                act, act ? mCause[i] : 2'd0, (kk == 3 + l)};
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [10:0] ob;
        logic [31:0] oepc, opc;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                ob   = {excpt_ctrl1, mem_addr_sel1, mem_rd1, epc_write1, pc_write1, busy1, cause1, done1};
                oepc = epc_data1;
                opc  = pc_data1;
            end else begin
                ob   = {excpt_ctrl3, mem_addr_sel3, mem_rd3, epc_write3, pc_write3, busy3, cause3, done3};
                oepc = epc_data3;
                opc  = pc_data3;
            end
            checkOne(i == 0 ? "ctl_bundle_L1" : "ctl_bundle_L3", 32'(ob), 32'(expBundle(i)));
            if (phase[i] == 1)
                checkOne(i == 0 ? "epc_data_L1" : "epc_data_L3", oepc, pc_in - 32'd4);
            if (phase[i] == 3 + lat[i])
                checkOne(i == 0 ? "pc_data_L1" : "pc_data_L3", opc, {24'd0, mByte[i]});
            doneCount[i] += int'(ob[0]);
        end
    endtask

    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                phase[i]  = 0;
                mCause[i] = 2'd0;
            end else if (phase[i] == 0) begin
                if (refCause(op_invalid, overflow, div_zero) != 2'd0) begin
                    phase[i]  = 1;
                    mCause[i] = refCause(op_invalid, overflow, div_zero);
                end
            end else if (phase[i] == 3 + lat[i]) begin
                phase[i]  = 0;
                mCause[i] = 2'd0;
            end else begin
                if (phase[i] == 2 + lat[i]) mByte[i] = mem_data_in[7:0];
                phase[i]++;
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            phase[i]  = 0;
            mCause[i] = 2'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        if (randMem) mem_data_in = $urandom;
    endtask

    task automatic applyStimulus(input logic oi, input logic ov, input logic dz, input logic [31:0] pc);
        op_invalid = oi;
        overflow   = ov;
        div_zero   = dz;
        pc_in      = pc;
    endtask

    initial begin
        logic [31:0] tmp;
        int          dc0, dc1;

        lat[0] = 1;
        lat[1] = 3;
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0; mCause[i] = 2'd0; mByte[i] = 8'd0; doneCount[i] = 0;
        end
        randMem     = 1'b1;
        reset       = 1'b0;
        mem_data_in = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset state.
        #3;
        checkOutput();
        checkOne("rst_epc_data", epc_data1, 32'd0);
        checkOne("rst_pc_data", pc_data3, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();

        // Overflow with pc 0x40 and handler byte 0x80.
        randMem = 1'b0;
        tmp = $urandom;
        mem_data_in = {tmp[31:8], 8'h80};
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h40);
        checkOne("t1_epc_data", epc_data1, 32'h3C);
        checkOne("t1_epc_write", 32'(epc_write1), 32'd1);
        checkOne("t1_cause", 32'(cause1), 32'd2);
        checkOne("t1_excpt_ctrl", 32'(excpt_ctrl1), 32'b001);
        tick(); tick(); tick();
        checkOne("t1_done_c4", 32'(done1), 32'd1);
        checkOne("t1_pc_data_c4", pc_data1, 32'h80);
        tick(); tick();
        checkOne("t1_done_L3_c6", 32'(done3), 32'd1);
        tick(); tick(); tick();
        randMem = 1'b1;

        // All three flags together.
        applyStimulus(1'b1, 1'b1, 1'b1, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, pc_in);
        checkOne("t2_cause", 32'(cause1), 32'd3);
        repeat (7) tick();

        // Opcode exception, then an overflow flag while waiting.
        dc0 = doneCount[0];
        dc1 = doneCount[1];
        applyStimulus(1'b1, 1'b0, 1'b0, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, pc_in);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, pc_in);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, pc_in);
        repeat (4) tick();
        checkOne("t3_done_once_L1", 32'(doneCount[0] - dc0), 32'd1);
        checkOne("t3_done_once_L3", 32'(doneCount[1] - dc1), 32'd1);
        checkOne("t3_cause_cleared", 32'(cause1), 32'd0);

        // Reset mid-WAIT, then restart.
        dc0 = doneCount[0];
        applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, pc_in);
        tick();
        tick();
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput();
        tick();
        tick();
        reset = 1'b1;
        checkOne("t4_no_pc_write", 32'(doneCount[0] - dc0), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, pc_in);
        checkOne("t4_restart_save", 32'(epc_write1), 32'd1);
        repeat (8) tick();

        // pc_in = 0 with the flag held: back-to-back exceptions.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) checkOne("t5_epc_wrap", epc_data1, 32'hFFFF_FFFC);
            checkOne("t5_b2b_done", 32'(done1), (c == 4 || c == 9) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (10) tick();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 500; n++) begin
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 5) == 0, $urandom);
            tick();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 60) == 0) begin
                #2;
                reset = 1'b0;
                modelReset();
                #1;
                checkOutput();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
